pc_fetch_ctrl: RTL and testbench

//  Next-PC and fetch-sequencing stage directly upstream of the PC register. Drives the

---
 rtl/pc_fetch_pkg.sv | 27 ++
 rtl/branch_cond_eval.sv | 32 +++
 rtl/pc_fetch_ctrl.sv | 145 ++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared constants and types for the fetch/next-PC stage.
package pc_fetch_pkg;

  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    CC_NE = 3'b000,
    CC_EQ = 3'b001,
    CC_GT = 3'b010,
    CC_LT = 3'b011,
    CC_GE = 3'b100,
    CC_LE = 3'b101,
    CC_OV = 3'b110,
    CC_UN = 3'b111
  } ccc_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    STALL  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam int unsigned PC_INC_DEF = 2;

endpackage

// File: rtl/branch_cond_eval.sv
// Branch condition evaluation: ccc code against {Z,V,N} flags.
module branch_cond_eval
  import pc_fetch_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic [2:0] flags,
  output logic       taken
);

  logic z, v, n;

  assign z = flags[2];
  assign v = flags[1];
  assign n = flags[0];

  // Decode the condition code into a taken decision
  always_comb begin
    taken = 1'b0;
    case (ccc)
      CC_NE:   taken = ~z;
      CC_EQ:   taken = z;
      CC_GT:   taken = ~z & ~n;
      CC_LT:   taken = n;
      CC_GE:   taken = z | ~n;
      CC_LE:   taken = n | z;
      CC_OV:   taken = v;
      CC_UN:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Next-PC and fetch sequencing stage with one-entry stall buffer and sticky halt.
// Optional feature macro: FETCH_PERF_CNT_EN (adds perf_taken / perf_stall counters).
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter int unsigned PC_W    = 16,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned PC_INC  = PC_INC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    pc_current,
  output logic [PC_W-1:0]    pc_new,
  output logic               imem_req,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic [2:0]         flags,
  input  logic [PC_W-1:0]    br_reg,
  input  logic               stall,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  output logic               halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        perf_taken,
  output logic [15:0]        perf_stall
`endif
);

  fetch_state_t       state, state_next;
  logic               buf_valid;
  logic [INSTR_W-1:0] buf_instr;
  logic [INSTR_W-1:0] cur_instr;
  logic [3:0]         op;
  logic [2:0]         ccc;
  logic [8:0]         imm9;
  logic               cond_true;
  logic               consume;
  logic               buf_load;
  logic [PC_W-1:0]    seq_pc;
  logic [PC_W-1:0]    br_off;

  // While the buffer holds an instruction, it is the one being decided on
  assign cur_instr = buf_valid ? buf_instr : instr;
  assign op        = cur_instr[15:12];
  assign ccc       = cur_instr[11:9];
  assign imm9      = cur_instr[8:0];
  assign seq_pc    = pc_current + PC_W'(PC_INC);
  assign br_off    = {{(PC_W-10){imm9[8]}}, imm9, 1'b0};

  branch_cond_eval u_cond (
    .ccc   (ccc),
    .flags (flags),
    .taken (cond_true)
  );

  // Next-state, handshake and next-PC selection
  always_comb begin
    state_next = state;
    pc_new     = pc_current;
    imem_req   = 1'b0;
    consume    = 1'b0;
    buf_load   = 1'b0;
    case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          if (stall) begin
            buf_load   = 1'b1;
            state_next = STALL;
          end else begin
            consume = 1'b1;
          end
        end
      end
      STALL: begin
        if (!stall) begin
          consume    = 1'b1;
          state_next = FETCH;
        end
      end
      HALTED: ;
      default: state_next = FETCH;
    endcase
    // HLT overrides the STALL->FETCH return so a buffered HLT still halts
    if (consume) begin
      case (op)
        OP_HLT: begin
          pc_new     = pc_current;
          state_next = HALTED;
        end
        OP_B:    pc_new = cond_true ? (seq_pc + br_off) : seq_pc;
        OP_BR:   pc_new = cond_true ? br_reg : seq_pc;
        default: pc_new = seq_pc;
      endcase
    end
  end

  // State, buffer and decode-side output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      buf_valid   <= 1'b0;
      buf_instr   <= '0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= state_next;
      instr_valid <= consume;
      halted      <= (state_next == HALTED);
      if (consume) begin
        instr_out <= cur_instr;
      end
      if (buf_load) begin
        buf_valid <= 1'b1;
        buf_instr <= instr;
      end else if (consume) begin
        buf_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic taken;

  assign taken = consume && ((op == OP_B) || (op == OP_BR)) && cond_true;

  // Saturating taken-branch and stall-cycle counters
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_taken <= '0;
      perf_stall <= '0;
    end else begin
      if (taken && (perf_taken != '1)) begin
        perf_taken <= perf_taken + 16'd1;
      end
      if ((state == STALL) && (perf_stall != '1)) begin
        perf_stall <= perf_stall + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed, table-driven bench for pc_fetch_ctrl (default build).
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_current;
  logic [15:0] pc_new;
  logic        imem_req;
  logic        imem_ready;
  logic [15:0] instr;
  logic [2:0]  flags;
  logic [15:0] br_reg;
  logic        stall;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        halted;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.PC_W(16), .INSTR_W(16), .PC_INC(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_current  (pc_current),
    .pc_new      (pc_new),
    .imem_req    (imem_req),
    .imem_ready  (imem_ready),
    .instr       (instr),
    .flags       (flags),
    .br_reg      (br_reg),
    .stall       (stall),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .halted      (halted)
  );

  typedef struct {
    logic [15:0] pc;
    logic [15:0] ins;
    logic [2:0]  flg;
    logic [15:0] br;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // flags = {Z,V,N}
    vecs[0]  = '{16'h0010, 16'h1234, 3'b000, 16'h0000, 16'h0012}; // sequential
    vecs[1]  = '{16'h0100, 16'hC3FE, 3'b100, 16'h0000, 16'h00FE}; // B EQ -2, Z=1
    vecs[2]  = '{16'h0100, 16'hC3FE, 3'b000, 16'h0000, 16'h0102}; // B EQ, Z=0
    vecs[3]  = '{16'h0100, 16'hDE00, 3'b000, 16'hABCC, 16'hABCC}; // BR UN
    vecs[4]  = '{16'hFFFE, 16'h1234, 3'b000, 16'h0000, 16'h0000}; // wrap
    vecs[5]  = '{16'h0200, 16'hC004, 3'b000, 16'h0000, 16'h020A}; // B NE +4
    vecs[6]  = '{16'h0300, 16'hC404, 3'b001, 16'h0000, 16'h0302}; // B GT, N=1
    vecs[7]  = '{16'h0300, 16'hC604, 3'b001, 16'h0000, 16'h030A}; // B LT, N=1
    vecs[8]  = '{16'h0300, 16'hCC04, 3'b010, 16'h0000, 16'h030A}; // B OV, V=1
    vecs[9]  = '{16'h0400, 16'hDA00, 3'b000, 16'h1234, 16'h0402}; // BR LE untaken
    vecs[10] = '{16'h0300, 16'hC804, 3'b100, 16'h0000, 16'h030A}; // B GE, Z=1
    vecs[11] = '{16'h0000, 16'hCFFC, 3'b000, 16'h0000, 16'hFFFA}; // B UN -4 wrap

    rst = 1'b1; pc_current = '0; imem_ready = 1'b0; instr = '0;
    flags = '0; br_reg = '0; stall = 1'b0;

    // Reset held two cycles
    tick();
    tick();
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_instr_out", 32'(instr_out), 32'h0);
    rst = 1'b0;
    tick();
    check("post_rst_imem_req", 32'(imem_req), 32'd1);
    check("post_rst_idle_pc", 32'(pc_new), 32'h0000);

    // Back-to-back consumes from the vector table
    for (int i = 0; i < 12; i++) begin
      pc_current = vecs[i].pc;
      instr      = vecs[i].ins;
      flags      = vecs[i].flg;
      br_reg     = vecs[i].br;
      imem_ready = 1'b1;
      stall      = 1'b0;
      #1;
      check($sformatf("vec%0d_pc_new", i), 32'(pc_new), 32'(vecs[i].exp_pc));
      check($sformatf("vec%0d_imem_req", i), 32'(imem_req), 32'd1);
      tick();
      check($sformatf("vec%0d_instr_out", i), 32'(instr_out), 32'(vecs[i].ins));
      check($sformatf("vec%0d_instr_valid", i), 32'(instr_valid), 32'd1);
    end

    // Idle fetch: no response means hold PC and no valid next cycle
    imem_ready = 1'b0; pc_current = 16'h0444; flags = '0;
    #1;
    check("idle_pc_hold", 32'(pc_new), 32'h0444);
    tick();
    check("idle_valid_low", 32'(instr_valid), 32'd0);

    // Stall with buffering, stall held 3 cycles
    pc_current = 16'h0500; instr = 16'h2222; imem_ready = 1'b1; stall = 1'b1;
    #1;
    check("stall_c1_pc", 32'(pc_new), 32'h0500);
    tick();
    instr = 16'h3333; imem_ready = 1'b0;
    #1;
    check("stall_c2_pc", 32'(pc_new), 32'h0500);
    check("stall_c2_req", 32'(imem_req), 32'd0);
    check("stall_c2_valid", 32'(instr_valid), 32'd0);
    tick();
    check("stall_c3_pc", 32'(pc_new), 32'h0500);
    check("stall_c3_valid", 32'(instr_valid), 32'd0);
    tick();
    stall = 1'b0;
    #1;
    check("unstall_pc", 32'(pc_new), 32'h0502);
    tick();
    check("unstall_instr_out", 32'(instr_out), 32'h2222);
    check("unstall_valid", 32'(instr_valid), 32'd1);
    check("unstall_req", 32'(imem_req), 32'd1);
    tick();
    check("no_dup_valid", 32'(instr_valid), 32'd0);

    // Halt
    pc_current = 16'h0600; instr = 16'hF000; imem_ready = 1'b1;
    #1;
    check("hlt_pc", 32'(pc_new), 32'h0600);
    tick();
    check("hlt_instr_out", 32'(instr_out), 32'hF000);
    check("hlt_valid", 32'(instr_valid), 32'd1);
    check("hlt_halted", 32'(halted), 32'd1);
    check("hlt_req", 32'(imem_req), 32'd0);
    instr = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("halted_pc_%0d", i), 32'(pc_new), 32'h0600);
      tick();
      check($sformatf("halted_valid_%0d", i), 32'(instr_valid), 32'd0);
      check($sformatf("halted_sticky_%0d", i), 32'(halted), 32'd1);
    end
    imem_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("hlt_rst_halted", 32'(halted), 32'd0);
    check("hlt_rst_req", 32'(imem_req), 32'd1);

    // Reset while in STALL drops the buffer; response in reset cycle discarded
    pc_current = 16'h0700; instr = 16'h4444; imem_ready = 1'b1; stall = 1'b1;
    tick();
    instr = 16'h5555; stall = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; imem_ready = 1'b0;
    check("midrst_valid", 32'(instr_valid), 32'd0);
    check("midrst_req", 32'(imem_req), 32'd1);
    #1;
    check("midrst_pc_hold", 32'(pc_new), 32'h0700);
    tick();
    check("midrst_no_emit", 32'(instr_valid), 32'd0);
    check("midrst_instr_out", 32'(instr_out), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
